// File: rtl/stream_demux1_2.sv
// stream_demux1_2: 1:2 stream demultiplexer with a 2-entry FIFO per output.
// Each accepted input word is steered to out0 or out1 by in_sel. Every output
// has its own registered 2-entry FIFO, so in_ready depends only on registered
// occupancy and in_sel, never on the downstream ready signals.
// Optional feature macro: DEMUX_STATS_EN adds per-output pop counters
// (out0_count / out1_count, CNT_WIDTH bits, wrapping).

// Two-entry FIFO with registered head/valid, used once per output.
module stream_demux1_2_fifo2 #(
  parameter int WIDTH     = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] count
`endif
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e             occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             valid_q, valid_d;
  logic             pop;

  // The consumer only takes a word that is actually presented.
  assign pop = valid_q & ready;

  // Next occupancy and storage contents from the push/pop combination.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          head_d = push_data;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          // Head leaves and the new word takes its place.
          head_d = push_data;
        end else if (push) begin
          tail_d = push_data;
          occ_d  = OCC_TWO;
        end else if (pop) begin
          occ_d  = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        // The top never pushes into a full FIFO, so only a pop can happen.
        if (pop) begin
          head_d = tail_q;
          occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
    valid_d = (occ_d != OCC_EMPTY);
  end

  // Occupancy, valid flag and both storage slots.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the data slots are reset as well, because the head is driven
      // straight onto the output port and must read zero during reset.
      occ_q   <= OCC_EMPTY;
      valid_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      occ_q   <= occ_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign full  = (occ_q == OCC_TWO);
  assign valid = valid_q;
  assign data  = head_q;

`ifdef DEMUX_STATS_EN
  logic [CNT_WIDTH-1:0] count_q;

  // Pop counter; wraps to zero after all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (pop) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign count = count_q;
`endif

endmodule

// Top level: steering, input handshake and the two output FIFOs.
module stream_demux1_2 #(
  parameter int WIDTH     = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] out0_count,
  output logic [CNT_WIDTH-1:0] out1_count
`endif
);

  logic full0, full1;
  logic push0, push1;

  // A full selected output stalls the input even when the other output has
  // room; the producer must hold in_sel/in_data while stalled. Gating with
  // reset keeps in_ready low for as long as reset is asserted.
  assign in_ready = reset & ~(in_sel ? full1 : full0);
  assign push0    = in_valid & in_ready & ~in_sel;
  assign push1    = in_valid & in_ready &  in_sel;

  stream_demux1_2_fifo2 #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_fifo0 (
    .clk       (clk),
    .reset     (reset),
    .push      (push0),
    .push_data (in_data),
    .full      (full0),
    .valid     (out0_valid),
    .ready     (out0_ready),
    .data      (out0_data)
`ifdef DEMUX_STATS_EN
    ,
    .count     (out0_count)
`endif
  );

  stream_demux1_2_fifo2 #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_fifo1 (
    .clk       (clk),
    .reset     (reset),
    .push      (push1),
    .push_data (in_data),
    .full      (full1),
    .valid     (out1_valid),
    .ready     (out1_ready),
    .data      (out1_data)
`ifdef DEMUX_STATS_EN
    ,
    .count     (out1_count)
`endif
  );

endmodule

// File: tb/tb_stream_demux1_2.sv
// Self-checking bench for stream_demux1_2: directed scenarios plus a
// randomized run against a per-output queue model.
module tb_stream_demux1_2;

  localparam int WIDTH     = 64;
  localparam int CNT_WIDTH = 4;
  localparam int N_WORDS   = 10000;
  localparam int LIMIT     = 60000;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready, in_sel;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid, out0_ready, out1_valid, out1_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
`ifdef DEMUX_STATS_EN
  logic [CNT_WIDTH-1:0] out0_count, out1_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stream_demux1_2 #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef DEMUX_STATS_EN
    ,
    .out0_count (out0_count),
    .out1_count (out1_count)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 64'h55;
    out0_ready = 1'b0; out1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL rst_in_ready: got %0b expected 0", in_ready); end
    n_checks++; if (out0_valid !== 1'b0) begin n_errors++; $display("FAIL rst_out0_valid: got %0b expected 0", out0_valid); end
    n_checks++; if (out1_valid !== 1'b0) begin n_errors++; $display("FAIL rst_out1_valid: got %0b expected 0", out1_valid); end
    n_checks++; if (out0_data !== '0) begin n_errors++; $display("FAIL rst_out0_data: got %0h expected 0", out0_data); end
    n_checks++; if (out1_data !== '0) begin n_errors++; $display("FAIL rst_out1_data: got %0h expected 0", out1_data); end
`ifdef DEMUX_STATS_EN
    n_checks++; if (out0_count !== '0) begin n_errors++; $display("FAIL rst_out0_count: got %0h expected 0", out0_count); end
`endif
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_release_ready: got %0b expected 1", in_ready); end
    tick;
  endtask

  task automatic test_reset_midstream;
    logic [WIDTH-1:0] words [4];
    words[0] = 64'h11; words[1] = 64'h33; words[2] = 64'h22; words[3] = 64'h44;
    out0_ready = 1'b0; out1_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = words[i]; in_sel = i[0];
      tick;
    end
    in_data = 64'hEE; in_sel = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL mid_full_stall: got %0b expected 0", in_ready); end
    n_checks++; if (out0_data !== 64'h11) begin n_errors++; $display("FAIL mid_out0_head: got %0h expected 11", out0_data); end
    n_checks++; if (out1_data !== 64'h33) begin n_errors++; $display("FAIL mid_out1_head: got %0h expected 33", out1_data); end
    reset = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL mid_rst_in_ready: got %0b expected 0", in_ready); end
    n_checks++; if (out0_valid !== 1'b0) begin n_errors++; $display("FAIL mid_rst_out0_valid: got %0b expected 0", out0_valid); end
    n_checks++; if (out1_valid !== 1'b0) begin n_errors++; $display("FAIL mid_rst_out1_valid: got %0b expected 0", out1_valid); end
    n_checks++; if (out0_data !== '0) begin n_errors++; $display("FAIL mid_rst_out0_data: got %0h expected 0", out0_data); end
    n_checks++; if (out1_data !== '0) begin n_errors++; $display("FAIL mid_rst_out1_data: got %0h expected 0", out1_data); end
    tick;
    in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
    reset = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL mid_release_ready: got %0b expected 1", in_ready); end
    tick;
    n_checks++; if (out0_valid !== 1'b0) begin n_errors++; $display("FAIL mid_discard_out0: got %0b expected 0", out0_valid); end
    n_checks++; if (out1_valid !== 1'b0) begin n_errors++; $display("FAIL mid_discard_out1: got %0b expected 0", out1_valid); end
  endtask

  task automatic test_steering;
    out0_ready = 1'b1; out1_ready = 1'b1;
    in_valid = 1'b1; in_data = 64'd5; in_sel = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL steer_ready0: got %0b expected 1", in_ready); end
    tick;
    in_data = 64'd10; in_sel = 1'b1;
    #1;
    n_checks++; if (out0_valid !== 1'b1) begin n_errors++; $display("FAIL steer_out0_valid: got %0b expected 1", out0_valid); end
    n_checks++; if (out0_data !== 64'd5) begin n_errors++; $display("FAIL steer_out0_data: got %0d expected 5", out0_data); end
    n_checks++; if (out1_valid !== 1'b0) begin n_errors++; $display("FAIL steer_out1_early: got %0b expected 0", out1_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL steer_ready1: got %0b expected 1", in_ready); end
    tick;
    in_valid = 1'b0;
    #1;
    n_checks++; if (out0_valid !== 1'b0) begin n_errors++; $display("FAIL steer_out0_once: got %0b expected 0", out0_valid); end
    n_checks++; if (out1_valid !== 1'b1) begin n_errors++; $display("FAIL steer_out1_valid: got %0b expected 1", out1_valid); end
    n_checks++; if (out1_data !== 64'd10) begin n_errors++; $display("FAIL steer_out1_data: got %0d expected 10", out1_data); end
    tick;
    n_checks++; if (out1_valid !== 1'b0) begin n_errors++; $display("FAIL steer_out1_once: got %0b expected 0", out1_valid); end
  endtask

  task automatic test_backpressure;
    out0_ready = 1'b0; out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 64'd100;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_accept100: got %0b expected 1", in_ready); end
    tick;
    in_data = 64'd50;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_accept50: got %0b expected 1", in_ready); end
    tick;
    in_data = 64'd77;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_stall77: got %0b expected 0", in_ready); end
    n_checks++; if (out0_data !== 64'd100) begin n_errors++; $display("FAIL bp_head100: got %0d expected 100", out0_data); end
    tick;
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_still_stalled: got %0b expected 0", in_ready); end
    out0_ready = 1'b1;
    tick;
    n_checks++; if (out0_data !== 64'd50) begin n_errors++; $display("FAIL bp_order50: got %0d expected 50", out0_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_unstall: got %0b expected 1", in_ready); end
    tick;
    in_valid = 1'b0;
    #1;
    n_checks++; if (out0_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid77: got %0b expected 1", out0_valid); end
    n_checks++; if (out0_data !== 64'd77) begin n_errors++; $display("FAIL bp_order77: got %0d expected 77", out0_data); end
    tick;
    n_checks++; if (out0_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drained: got %0b expected 0", out0_valid); end
  endtask

  task automatic test_independence;
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 64'd1;
    tick;
    in_data = 64'd2;
    tick;
    in_sel = 1'b1; in_data = 64'd9;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL ind_ready_sel1: got %0b expected 1", in_ready); end
    tick;
    in_sel = 1'b0; in_data = 64'd3;
    #1;
    n_checks++; if (out1_valid !== 1'b1) begin n_errors++; $display("FAIL ind_out1_valid: got %0b expected 1", out1_valid); end
    n_checks++; if (out1_data !== 64'd9) begin n_errors++; $display("FAIL ind_out1_data: got %0d expected 9", out1_data); end
    n_checks++; if (out0_data !== 64'd1) begin n_errors++; $display("FAIL ind_out0_head: got %0d expected 1", out0_data); end
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL ind_ready_sel0: got %0b expected 0", in_ready); end
    in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
    tick;
    n_checks++; if (out0_data !== 64'd2) begin n_errors++; $display("FAIL ind_out0_second: got %0d expected 2", out0_data); end
    n_checks++; if (out1_valid !== 1'b0) begin n_errors++; $display("FAIL ind_out1_drained: got %0b expected 0", out1_valid); end
    tick;
    n_checks++; if (out0_valid !== 1'b0) begin n_errors++; $display("FAIL ind_out0_drained: got %0b expected 0", out0_valid); end
  endtask

  task automatic test_push_pop;
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 64'd20;
    tick;
    in_data = 64'd21; out1_ready = 1'b1;
    #1;
    n_checks++; if (out1_data !== 64'd20) begin n_errors++; $display("FAIL pp_head20: got %0d expected 20", out1_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL pp_ready_cnt1: got %0b expected 1", in_ready); end
    tick;
    in_data = 64'd22; out1_ready = 1'b0;
    #1;
    n_checks++; if (out1_valid !== 1'b1) begin n_errors++; $display("FAIL pp_valid21: got %0b expected 1", out1_valid); end
    n_checks++; if (out1_data !== 64'd21) begin n_errors++; $display("FAIL pp_head21: got %0d expected 21", out1_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL pp_still_cnt1: got %0b expected 1", in_ready); end
    tick;
    in_valid = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL pp_now_full: got %0b expected 0", in_ready); end
    out1_ready = 1'b1;
    tick;
    n_checks++; if (out1_data !== 64'd22) begin n_errors++; $display("FAIL pp_head22: got %0d expected 22", out1_data); end
    tick;
    n_checks++; if (out1_valid !== 1'b0) begin n_errors++; $display("FAIL pp_drained: got %0b expected 0", out1_valid); end
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] q0 [$];
    logic [WIDTH-1:0] q1 [$];
    int   sent    = 0;
    int   cyc     = 0;
    bit   holding = 1'b0;
    in_valid = 1'b0;
    while ((sent < N_WORDS || q0.size() != 0 || q1.size() != 0 || holding) && cyc < LIMIT) begin
      if (!holding) begin
        if (sent < N_WORDS && $urandom_range(3) != 0) begin
          in_valid = 1'b1; holding = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
        in_data = {$urandom, $urandom};
        in_sel  = 1'($urandom_range(1));
      end
      out0_ready = 1'($urandom_range(1));
      out1_ready = 1'($urandom_range(1));
      #1;
      n_checks++; if (in_ready !== ((in_sel ? q1.size() : q0.size()) != 2)) begin n_errors++; $display("FAIL rnd_in_ready: got %0b at cycle %0d", in_ready, cyc); end
      n_checks++; if (out0_valid !== (q0.size() != 0)) begin n_errors++; $display("FAIL rnd_out0_valid: got %0b expected %0b", out0_valid, q0.size() != 0); end
      n_checks++; if (out1_valid !== (q1.size() != 0)) begin n_errors++; $display("FAIL rnd_out1_valid: got %0b expected %0b", out1_valid, q1.size() != 0); end
      if (out0_valid && out0_ready && q0.size() != 0) begin
        n_checks++; if (out0_data !== q0[0]) begin n_errors++; $display("FAIL rnd_out0_data: got %0h expected %0h", out0_data, q0[0]); end
        void'(q0.pop_front());
      end
      if (out1_valid && out1_ready && q1.size() != 0) begin
        n_checks++; if (out1_data !== q1[0]) begin n_errors++; $display("FAIL rnd_out1_data: got %0h expected %0h", out1_data, q1[0]); end
        void'(q1.pop_front());
      end
      if (in_valid && in_ready) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
        sent++;
        holding = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++; if (cyc >= LIMIT) begin n_errors++; $display("FAIL rnd_timeout: sent %0d of %0d words in %0d cycles", sent, N_WORDS, cyc); end
  endtask

`ifdef DEMUX_STATS_EN
  task automatic test_stats;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    n_checks++; if (out0_count !== '0) begin n_errors++; $display("FAIL stats_reset: got %0d expected 0", out0_count); end
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_sel = 1'b0; in_data = 64'(i);
      tick;
    end
    in_valid = 1'b0;
    tick;
    n_checks++; if (out0_count !== 4'd1) begin n_errors++; $display("FAIL stats_wrap: got %0d expected 1", out0_count); end
    n_checks++; if (out1_count !== 4'd0) begin n_errors++; $display("FAIL stats_out1: got %0d expected 0", out1_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_midstream();
    test_steering();
    test_backpressure();
    test_independence();
    test_push_pop();
    test_random();
`ifdef DEMUX_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
